// File: rtl/ram_io_responder.sv
// ram_io_responder: byte-wide RAM/IO responder at the memory controller's
// RAM port. One-cycle registered reads, RAM writes, a TX byte queue fed by
// CPU writes, an RX byte queue drained by CPU reads, a sticky simulation-end
// register, and registered TX back-pressure toward the controller.
module ram_io_responder #(
    parameter int RAM_ADDR_WIDTH = 17,
    parameter int TX_DEPTH       = 8,
    parameter int RX_DEPTH       = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        iMEM_rw,
    input  logic [31:0] iMEM_addr,
    input  logic [7:0]  iMEM_dt,
    output logic [7:0]  oMEM_dt,
    output logic        oIO_buffer_full,
    output logic        oTX_valid,
    output logic [7:0]  oTX_data,
    input  logic        iTX_ready,
    input  logic        iRX_valid,
    input  logic [7:0]  iRX_data,
    output logic        oRX_full,
    output logic        oTX_overflow,
    output logic        oSIM_end,
    output logic [7:0]  oSIM_code
);

    localparam int TXW = $clog2(TX_DEPTH);
    localparam int RXW = $clog2(RX_DEPTH);
    localparam logic [TXW:0] C_TX_FULL   = (TXW+1)'(TX_DEPTH);
    localparam logic [TXW:0] C_TX_MARGIN = (TXW+1)'(TX_DEPTH - 2);
    localparam logic [RXW:0] C_RX_FULL   = (RXW+1)'(RX_DEPTH);

    // Storage arrays (never reset; RAM survives reset by design)
    logic [7:0] r_ram    [0:(2**RAM_ADDR_WIDTH)-1];
    logic [7:0] r_tx_mem [0:TX_DEPTH-1];
    logic [7:0] r_rx_mem [0:RX_DEPTH-1];

    logic [TXW-1:0] r_tx_wp, r_tx_rp;
    logic [TXW:0]   r_tx_cnt;
    logic [RXW-1:0] r_rx_wp, r_rx_rp;
    logic [RXW:0]   r_rx_cnt;

    logic [7:0] r_mem_dt;
    logic       r_io_full;
    logic       r_tx_ovf;
    logic       r_sim_end;
    logic [7:0] r_sim_code;

    // Address decode; bits above the I/O select and RAM index are don't-care
    logic                      w_is_io;
    logic [RAM_ADDR_WIDTH-1:0] w_ram_addr;
    logic                      w_off0, w_off4;
    logic                      w_unused_addr;

    assign w_is_io       = (iMEM_addr[17:16] == 2'b11);
    assign w_ram_addr    = iMEM_addr[RAM_ADDR_WIDTH-1:0];
    assign w_off0        = (iMEM_addr[2:0] == 3'd0);
    assign w_off4        = (iMEM_addr[2:0] == 3'd4);
    assign w_unused_addr = ^iMEM_addr[31:18];

    // Queue handshakes; a pop in the same cycle frees room for a push on a full queue
    logic w_tx_wr, w_tx_push, w_tx_pop, w_tx_ovf;
    logic w_rx_push, w_rx_pop;
    logic w_ram_wr, w_sim_wr;

    assign w_tx_pop  = rdy && (r_tx_cnt != '0) && iTX_ready;
    assign w_tx_wr   = rdy && w_is_io && iMEM_rw && w_off0;
    assign w_tx_push = w_tx_wr && ((r_tx_cnt != C_TX_FULL) || w_tx_pop);
    assign w_tx_ovf  = w_tx_wr && !w_tx_push;
    assign w_rx_pop  = rdy && w_is_io && !iMEM_rw && w_off0 && (r_rx_cnt != '0);
    assign w_rx_push = rdy && iRX_valid && ((r_rx_cnt != C_RX_FULL) || w_rx_pop);
    assign w_ram_wr  = rdy && !w_is_io && iMEM_rw;
    assign w_sim_wr  = rdy && w_is_io && iMEM_rw && w_off4 && !r_sim_end;

    logic [TXW:0] w_tx_cnt_next;
    logic [RXW:0] w_rx_cnt_next;
    logic [7:0]   w_rd_data;

    // Next occupancy of both queues from their push/pop strobes
    always_comb begin
        w_tx_cnt_next = r_tx_cnt;
        w_rx_cnt_next = r_rx_cnt;
        case ({w_tx_push, w_tx_pop})
            2'b10:   w_tx_cnt_next = r_tx_cnt + {{TXW{1'b0}}, 1'b1};
            2'b01:   w_tx_cnt_next = r_tx_cnt - {{TXW{1'b0}}, 1'b1};
            default: w_tx_cnt_next = r_tx_cnt;
        endcase
        case ({w_rx_push, w_rx_pop})
            2'b10:   w_rx_cnt_next = r_rx_cnt + {{RXW{1'b0}}, 1'b1};
            2'b01:   w_rx_cnt_next = r_rx_cnt - {{RXW{1'b0}}, 1'b1};
            default: w_rx_cnt_next = r_rx_cnt;
        endcase
    end

    // Read-data source: RX head at the UART offset, RAM byte for RAM reads, else zero
    always_comb begin
        w_rd_data = 8'h00;
        if (w_is_io) begin
            if (!iMEM_rw && w_off0 && (r_rx_cnt != '0)) begin
                w_rd_data = r_rx_mem[r_rx_rp];
            end else begin
                w_rd_data = 8'h00;
            end
        end else if (!iMEM_rw) begin
            w_rd_data = r_ram[w_ram_addr];
        end else begin
            w_rd_data = 8'h00;
        end
    end

    // Array writes: RAM, TX slot and RX slot (no reset on storage)
    always_ff @(posedge clk) begin
        if (w_ram_wr)  r_ram[w_ram_addr]  <= iMEM_dt;
        if (w_tx_push) r_tx_mem[r_tx_wp] <= iMEM_dt;
        if (w_rx_push) r_rx_mem[r_rx_wp] <= iRX_data;
    end

    // Control state, pointers and registered outputs; everything frozen while rdy is low
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tx_wp    <= '0;
            r_tx_rp    <= '0;
            r_tx_cnt   <= '0;
            r_rx_wp    <= '0;
            r_rx_rp    <= '0;
            r_rx_cnt   <= '0;
            r_mem_dt   <= 8'h00;
            r_io_full  <= 1'b0;
            r_tx_ovf   <= 1'b0;
            r_sim_end  <= 1'b0;
            r_sim_code <= 8'h00;
        end else if (rdy) begin
            r_mem_dt  <= w_rd_data;
            r_tx_cnt  <= w_tx_cnt_next;
            r_rx_cnt  <= w_rx_cnt_next;
            r_io_full <= (w_tx_cnt_next >= C_TX_MARGIN);
            if (w_tx_push) r_tx_wp <= r_tx_wp + {{(TXW-1){1'b0}}, 1'b1};
            if (w_tx_pop)  r_tx_rp <= r_tx_rp + {{(TXW-1){1'b0}}, 1'b1};
            if (w_rx_push) r_rx_wp <= r_rx_wp + {{(RXW-1){1'b0}}, 1'b1};
            if (w_rx_pop)  r_rx_rp <= r_rx_rp + {{(RXW-1){1'b0}}, 1'b1};
            if (w_tx_ovf)  r_tx_ovf <= 1'b1;
            if (w_sim_wr) begin
                r_sim_end  <= 1'b1;
                r_sim_code <= iMEM_dt;
            end
        end
    end

    assign oMEM_dt         = r_mem_dt;
    assign oIO_buffer_full = r_io_full;
    assign oTX_valid       = (r_tx_cnt != '0);
    assign oTX_data        = r_tx_mem[r_tx_rp];
    assign oRX_full        = (r_rx_cnt == C_RX_FULL);
    assign oTX_overflow    = r_tx_ovf;
    assign oSIM_end        = r_sim_end;
    assign oSIM_code       = r_sim_code;

endmodule

// File: tb/tb_ram_io_responder.sv
// Directed bench for ram_io_responder: table of RAM/IO access vectors plus
// hand-written sequences for queues, back-pressure, sim-end and reset.
module tb_ram_io_responder;

    logic        clk;
    logic        rst;
    logic        rdy;
    logic        iMEM_rw;
    logic [31:0] iMEM_addr;
    logic [7:0]  iMEM_dt;
    logic [7:0]  oMEM_dt;
    logic        oIO_buffer_full;
    logic        oTX_valid;
    logic [7:0]  oTX_data;
    logic        iTX_ready;
    logic        iRX_valid;
    logic [7:0]  iRX_data;
    logic        oRX_full;
    logic        oTX_overflow;
    logic        oSIM_end;
    logic [7:0]  oSIM_code;

    int total = 0;
    int bad   = 0;

    ram_io_responder dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .iMEM_rw(iMEM_rw), .iMEM_addr(iMEM_addr), .iMEM_dt(iMEM_dt),
        .oMEM_dt(oMEM_dt), .oIO_buffer_full(oIO_buffer_full),
        .oTX_valid(oTX_valid), .oTX_data(oTX_data), .iTX_ready(iTX_ready),
        .iRX_valid(iRX_valid), .iRX_data(iRX_data), .oRX_full(oRX_full),
        .oTX_overflow(oTX_overflow), .oSIM_end(oSIM_end), .oSIM_code(oSIM_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rw;
        logic [31:0] addr;
        logic [7:0]  dt;
        logic [7:0]  exp_dt;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Present one access, let it be taken at the next edge, sample 1 time unit later
    task automatic access(input logic rw, input logic [31:0] addr, input logic [7:0] dt);
        iMEM_rw   = rw;
        iMEM_addr = addr;
        iMEM_dt   = dt;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        access(1'b0, 32'h0000_0000, 8'h00);
    endtask

    initial begin
        vecs[0]  = '{1'b1, 32'h0000_0010, 8'hA5, 8'h00};
        vecs[1]  = '{1'b0, 32'h0000_0010, 8'h00, 8'hA5};
        vecs[2]  = '{1'b0, 32'h0002_0010, 8'h00, 8'hA5};
        vecs[3]  = '{1'b1, 32'h0001_FFFF, 8'h3C, 8'h00};
        vecs[4]  = '{1'b0, 32'h0001_FFFF, 8'h00, 8'h3C};
        vecs[5]  = '{1'b1, 32'h0000_0000, 8'h5A, 8'h00};
        vecs[6]  = '{1'b0, 32'hFFF0_0010, 8'h00, 8'hA5};
        vecs[7]  = '{1'b0, 32'h0003_0004, 8'h00, 8'h00};
        vecs[8]  = '{1'b0, 32'h0003_0002, 8'h00, 8'h00};
        vecs[9]  = '{1'b0, 32'h0000_0000, 8'h00, 8'h5A};
        vecs[10] = '{1'b1, 32'h0003_0006, 8'hFF, 8'h00};
        vecs[11] = '{1'b0, 32'h0001_FFFF, 8'h00, 8'h3C};

        rst = 1'b1; rdy = 1'b1;
        iMEM_rw = 1'b0; iMEM_addr = 32'h0; iMEM_dt = 8'h00;
        iTX_ready = 1'b0; iRX_valid = 1'b0; iRX_data = 8'h00;
        #2;
        chk("rst_mem_dt",   {24'h0, oMEM_dt}, 32'h0);
        chk("rst_io_full",  {31'h0, oIO_buffer_full}, 32'h0);
        chk("rst_tx_valid", {31'h0, oTX_valid}, 32'h0);
        chk("rst_rx_full",  {31'h0, oRX_full}, 32'h0);
        chk("rst_tx_ovf",   {31'h0, oTX_overflow}, 32'h0);
        chk("rst_sim_end",  {31'h0, oSIM_end}, 32'h0);
        chk("rst_sim_code", {24'h0, oSIM_code}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        // RAM / IO decode vectors
        for (int i = 0; i < 12; i++) begin
            access(vecs[i].rw, vecs[i].addr, vecs[i].dt);
            chk($sformatf("vec%0d_mem_dt", i), {24'h0, oMEM_dt}, {24'h0, vecs[i].exp_dt});
        end

        // rdy low: nothing accepted, outputs hold, RX fill frozen
        rdy = 1'b0; iRX_valid = 1'b1; iRX_data = 8'hEE;
        access(1'b1, 32'h0000_0010, 8'h11);
        access(1'b1, 32'h0003_0000, 8'h99);
        chk("frz_mem_dt",   {24'h0, oMEM_dt}, 32'h3C);
        chk("frz_tx_valid", {31'h0, oTX_valid}, 32'h0);
        rdy = 1'b1; iRX_valid = 1'b0;
        access(1'b0, 32'h0000_0010, 8'h00);
        chk("frz_ram_kept", {24'h0, oMEM_dt}, 32'hA5);
        access(1'b0, 32'h0003_0000, 8'h00);
        chk("frz_rx_empty", {24'h0, oMEM_dt}, 32'h0);

        // TX fill to overflow with consumer stalled
        for (int k = 0; k < 9; k++) begin
            access(1'b1, 32'h0003_0000, 8'h41 + 8'(k));
            chk($sformatf("txfill%0d_full", k), {31'h0, oIO_buffer_full}, {31'h0, (k >= 5)});
            chk($sformatf("txfill%0d_ovf", k), {31'h0, oTX_overflow}, {31'h0, (k == 8)});
        end
        idle();
        iTX_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("txdrain%0d_valid", k), {31'h0, oTX_valid}, 32'h1);
            chk($sformatf("txdrain%0d_data", k), {24'h0, oTX_data}, {24'h0, 8'h41 + 8'(k)});
            idle();
            chk($sformatf("txdrain%0d_full", k), {31'h0, oIO_buffer_full}, {31'h0, ((7 - k) >= 6)});
        end
        chk("txdrain_empty", {31'h0, oTX_valid}, 32'h0);
        iTX_ready = 1'b0;

        // RX queue: pops in order, empty read returns zero
        iRX_valid = 1'b1; iRX_data = 8'h31; idle();
        iRX_data = 8'h32; idle();
        iRX_valid = 1'b0;
        access(1'b0, 32'h0003_0000, 8'h00); chk("rx_pop0", {24'h0, oMEM_dt}, 32'h31);
        access(1'b0, 32'h0003_0000, 8'h00); chk("rx_pop1", {24'h0, oMEM_dt}, 32'h32);
        access(1'b0, 32'h0003_0000, 8'h00); chk("rx_pop2", {24'h0, oMEM_dt}, 32'h00);
        idle();
        iRX_valid = 1'b1;
        for (int k = 0; k < 9; k++) begin
            iRX_data = 8'h80 + 8'(k);
            idle();
            chk($sformatf("rxfill%0d_full", k), {31'h0, oRX_full}, {31'h0, (k >= 7)});
        end
        iRX_valid = 1'b0;
        for (int k = 0; k < 9; k++) begin
            access(1'b0, 32'h0003_0000, 8'h00);
            chk($sformatf("rxread%0d", k), {24'h0, oMEM_dt}, (k < 8) ? {24'h0, 8'h80 + 8'(k)} : 32'h0);
        end
        idle();

        // Simulation-end register: first write wins
        access(1'b1, 32'h0003_0004, 8'h2A);
        access(1'b1, 32'h0003_0004, 8'h07);
        idle();
        chk("sim_end",  {31'h0, oSIM_end}, 32'h1);
        chk("sim_code", {24'h0, oSIM_code}, 32'h2A);

        // Clear sticky state, then simultaneous push and pop on a full TX queue
        rst = 1'b1; #2;
        chk("rst2_ovf", {31'h0, oTX_overflow}, 32'h0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        for (int k = 0; k < 8; k++) access(1'b1, 32'h0003_0000, 8'h60 + 8'(k));
        iTX_ready = 1'b1;
        access(1'b1, 32'h0003_0000, 8'h68);
        iTX_ready = 1'b0;
        idle();
        chk("pp_ovf",  {31'h0, oTX_overflow}, 32'h0);
        chk("pp_full", {31'h0, oIO_buffer_full}, 32'h1);
        chk("pp_head", {24'h0, oTX_data}, 32'h61);
        iTX_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("pp_drain%0d", k), {24'h0, oTX_data}, {24'h0, 8'h61 + 8'(k)});
            idle();
        end
        chk("pp_empty", {31'h0, oTX_valid}, 32'h0);
        iTX_ready = 1'b0;

        // Async reset mid-drain with three bytes still queued
        for (int k = 0; k < 5; k++) access(1'b1, 32'h0003_0000, 8'h70 + 8'(k));
        access(1'b0, 32'h0000_0010, 8'h00);
        iTX_ready = 1'b1;
        idle(); idle();
        chk("mid_head", {24'h0, oTX_data}, 32'h72);
        #2 rst = 1'b1;
        #1;
        chk("mid_tx_valid", {31'h0, oTX_valid}, 32'h0);
        chk("mid_io_full",  {31'h0, oIO_buffer_full}, 32'h0);
        chk("mid_mem_dt",   {24'h0, oMEM_dt}, 32'h0);
        chk("mid_sim_end",  {31'h0, oSIM_end}, 32'h0);
        chk("mid_sim_code", {24'h0, oSIM_code}, 32'h0);
        chk("mid_rx_full",  {31'h0, oRX_full}, 32'h0);
        iTX_ready = 1'b0;
        @(negedge clk); rst = 1'b0;
        access(1'b0, 32'h0000_0010, 8'h00);
        chk("post_rst_ram", {24'h0, oMEM_dt}, 32'hA5);
        chk("post_rst_tx",  {31'h0, oTX_valid}, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ram_io_responder.md
# ram_io_responder

Byte-wide responder at the far end of the memory controller's RAM port. Serves one-cycle-latency byte reads and writes to a local RAM array, decodes a memory-mapped I/O window (UART TX/RX byte queues, simulation-end register), and drives the `io_buffer_full` back-pressure signal that stalls the controller. Sits between the CPU's memory controller and the testbench/board I/O.

## Interface
- `RAM_ADDR_WIDTH`, 17: RAM byte-address bits (128 KiB array)
- `TX_DEPTH`, 8: TX queue entries, power of two, >= 4
- `RX_DEPTH`, 8: RX queue entries, power of two, >= 2

- `clk`  in  1  system clock, all state on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `rdy`  in  1  global enable; low = no access accepted, all state frozen
- `iMEM_rw`  in  1  0 = read, 1 = write
- `iMEM_addr`  in  32  byte address
- `iMEM_dt`  in  8  write data
- `oMEM_dt`  out  8  read data, registered
- `oIO_buffer_full`  out  1  TX queue near full, registered
- `oTX_valid`  out  1  TX queue non-empty
- `oTX_data`  out  8  TX queue head byte
- `iTX_ready`  in  1  consumer takes head when `oTX_valid && iTX_ready`
- `iRX_valid`  in  1  producer offers a byte
- `iRX_data`  in  8  offered byte
- `oRX_full`  out  1  RX queue full; offered bytes dropped
- `oTX_overflow`  out  1  sticky: write to full TX queue occurred
- `oSIM_end`  out  1  sticky: simulation-end register written
- `oSIM_code`  out  8  byte written to simulation-end register

## Operation
- Decode: `iMEM_addr[17:16] == 2'b11` is I/O; else RAM at `iMEM_addr[RAM_ADDR_WIDTH-1:0]`. Upper address bits ignored.
- RAM write (`rw=1`, RAM): `ram[a] <= iMEM_dt`; `oMEM_dt <= 0`.
- RAM read (`rw=0`, RAM): `oMEM_dt <= ram[a]`.
- I/O at `addr[2:0]==0` (0x30000): write pushes `iMEM_dt` into TX queue; if TX full, byte dropped, `oTX_overflow <= 1`. Read pops RX head into `oMEM_dt`; RX empty -> `oMEM_dt <= 0`, no pop.
- I/O at `addr[2:0]==4` (0x30004): write sets `oSIM_end <= 1`, `oSIM_code <= iMEM_dt` (first write wins; later writes ignored). Read returns 0.
- Other I/O offsets: write ignored, read returns 0.
- The controller idles with `rw=0`; reads have no side effects except at 0x30000. The controller must not leave 0x30000 on the bus with `rw=0` unless it intends a pop.
- TX queue: circular buffer, read/write pointers `log2(TX_DEPTH)` bits wrapping naturally, count `log2(TX_DEPTH)+1` bits. Push and pop in same cycle: both happen, count unchanged (push accepted even when full if a pop occurs that cycle).
- RX queue: same structure; push when `iRX_valid && !oRX_full`; pop by CPU read. Simultaneous push/pop on full RX: pop then push, both accepted.
- `oIO_buffer_full <= (tx_count_next >= TX_DEPTH-2)`: two-entry margin covers a write already issued when the controller samples the flag.
- RAM contents are not reset and are undefined until written (bench preloads).

## Timing
- Read latency 1: address/`rw` presented in cycle N, `oMEM_dt` valid in cycle N+1, held until next accepted access.
- Write commits at the rising edge ending cycle N; a read of the same address in N+1 returns the new byte.
- `oTX_valid`/`oTX_data` combinational from queue state; pushed byte visible the cycle after the push edge.
- `oIO_buffer_full` asserts the cycle after count reaches `TX_DEPTH-2`, deasserts the cycle after it falls below.
- `rdy=0`: no RAM/IO access, no queue push/pop (TX drain and RX fill also frozen), all outputs hold.
- Reset (async, any time, including mid-burst): `oMEM_dt=0`, `oIO_buffer_full=0`, `oTX_valid=0`, `oRX_full=0`, `oTX_overflow=0`, `oSIM_end=0`, `oSIM_code=0`; both queues empty; RAM untouched. First access accepted on the first edge after `rst` falls.

## Test plan
- Write 0xA5 to 0x00010, read 0x00010 next cycle -> `oMEM_dt=0xA5` one cycle after read address; read 0x20010 (aliased outside I/O) -> RAM byte.
- With `iTX_ready=0`, write 0x41..0x46 to 0x30000 -> `oIO_buffer_full` rises after 6th write (TX_DEPTH=8); 2 more writes accepted, 9th sets `oTX_overflow=1`; raise `iTX_ready` -> 0x41..0x48 drained in order, full flag clears when count < 6.
- Push 0x31, 0x32 on RX; read 0x30000 three times -> 0x31, 0x32, 0x00; `oRX_full` asserted after 8 pushes, 9th push dropped.
- Write 0x2A to 0x30004, then 0x07 -> `oSIM_end=1`, `oSIM_code=0x2A` held.
- Simultaneous TX push and pop with count=8 -> push accepted, count stays 8, no overflow.
- Assert `rst` mid-TX-drain with 3 bytes queued -> all outputs zero immediately, queue empty; prior RAM writes still readable after release.
